// File: rtl/wb_init_pkg.sv
// Shared types and constants for the Wishbone logic-analyzer initiator.
// Bus widths, the FSM state encoding and the default timeout read-back value.
package wb_init_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Clear/enable saturating cycle counter with a terminal-count flag.
// The flag marks the last permitted wait cycle; it is tied low when TIMEOUT_CYCLES is 0.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TC_VAL  = (TIMEOUT_CYCLES == 0) ? {CW{1'b0}} : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Counter register: clear wins over enable, and the count sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign tc = 1'b0;
    end else begin : g_timeout
      assign tc = (cnt_r == TC_VAL);
    end
  endgenerate

endmodule

// File: rtl/wb_la_initiator.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Each command runs one bus cycle and yields a buffered response (read data or timeout error).
module wb_la_initiator
  import wb_init_pkg::*;
#(
  parameter int                  TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_W-1:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy_o
);

  state_e                state_r,     state_s;
  logic                  cyc_r,       cyc_s;
  logic                  we_r,        we_s;
  logic [WB_ADR_W-1:0]   adr_r,       adr_s;
  logic [WB_DAT_W-1:0]   dat_r,       dat_s;
  logic [WB_SEL_W-1:0]   sel_r,       sel_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic [WB_DAT_W-1:0]   rsp_dat_r,   rsp_dat_s;
  logic                  rsp_err_r,   rsp_err_s;
  logic                  cmd_ready_r, cmd_ready_s;
  logic                  busy_r,      busy_s;
  logic                  clr_s, en_s, tc_s;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .clr  (clr_s),
    .en   (en_s),
    .tc   (tc_s)
  );

  // Next-state and next-output logic; everything holds unless a transition updates it.
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    sel_s       = sel_r;
    rsp_valid_s = rsp_valid_r;
    rsp_dat_s   = rsp_dat_r;
    rsp_err_s   = rsp_err_r;
    clr_s       = 1'b0;
    en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_r) begin
          we_s    = cmd_we_i;
          adr_s   = cmd_adr_i;
          dat_s   = cmd_dat_i;
          sel_s   = cmd_sel_i;
          cyc_s   = 1'b1;
          clr_s   = 1'b1;
          state_s = BUS;
        end else begin
          state_s = IDLE;
        end
      end
      BUS: begin
        // Ack is checked first so it wins on the timeout boundary cycle.
        if (wbm_ack_i) begin
          cyc_s       = 1'b0;
          rsp_dat_s   = we_r ? {WB_DAT_W{1'b0}} : wbm_dat_i;
          rsp_err_s   = 1'b0;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else if (tc_s) begin
          en_s        = 1'b1;
          cyc_s       = 1'b0;
          rsp_dat_s   = ERR_DATA;
          rsp_err_s   = 1'b1;
          rsp_valid_s = 1'b1;
          state_s     = RESP;
        end else begin
          en_s = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        cyc_s       = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
    cmd_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
  end

  // State and output registers; reset drops the bus cycle and any pending response at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r     <= IDLE;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= {WB_ADR_W{1'b0}};
      dat_r       <= {WB_DAT_W{1'b0}};
      sel_r       <= {WB_SEL_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= {WB_DAT_W{1'b0}};
      rsp_err_r   <= 1'b0;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cyc_r       <= cyc_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      sel_r       <= sel_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign cmd_ready_o = cmd_ready_r;
  assign wbm_cyc_o   = cyc_r;
  assign wbm_stb_o   = cyc_r;
  assign wbm_we_o    = we_r;
  assign wbm_adr_o   = adr_r;
  assign wbm_dat_o   = dat_r;
  assign wbm_sel_o   = sel_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_dat_o   = rsp_dat_r;
  assign rsp_err_o   = rsp_err_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_wb_la_initiator.sv
// Scoreboard bench for wb_la_initiator: directed and random transfers against a
// bench-side Wishbone responder, with expected responses queued at issue time.
module tb_wb_la_initiator;

  localparam int          T    = 8;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = 32'h0, cmd_dat_i = 32'h0;
  logic [3:0]  cmd_sel_i = 4'h0;
  logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = 32'h0;
  logic [3:0]  wbm_sel_o;
  logic        busy_o;

  wb_la_initiator #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        err;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  // responder and consumer configuration
  int          r_waits = 0;
  bit          r_noack = 1'b0;
  logic [31:0] r_rdata = 32'h0;
  bit          stray_ack = 1'b0;
  int          hold = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endfunction

  // Wishbone responder: acks after r_waits wait states unless told to stay silent
  int wcnt = 0;
  initial forever begin
    @(posedge wb_clk_i); #1;
    if (wbm_cyc_o && wbm_stb_o) begin
      wbm_ack_i = !r_noack && (wcnt == r_waits);
      wbm_dat_i = wbm_ack_i ? r_rdata : $urandom;
      wcnt++;
    end else begin
      wcnt = 0;
      wbm_ack_i = stray_ack;
      wbm_dat_i = $urandom;
    end
  end

  // Response consumer: withholds rsp_ready for 'hold' cycles of a presented response
  initial forever begin
    @(posedge wb_clk_i); #1;
    if (rsp_valid_o && hold > 0) begin
      rsp_ready_i = 1'b0;
      hold--;
    end else begin
      rsp_ready_i = 1'b1;
    end
  end

  // Monitor: bus qualification, response scoreboard, hold stability and latency
  int cyc_idx = 0, acc_idx = 0, cyc_len = 0;
  bit in_rsp = 1'b0;
  logic [31:0] cur_dat;
  logic cur_err;
  initial forever begin
    exp_t e;
    @(negedge wb_clk_i);
    cyc_idx++;
    if (!wb_rst_ni) begin
      in_rsp  = 1'b0;
      cyc_len = 0;
    end else begin
      chk1("busy", busy_o, wbm_cyc_o | rsp_valid_o);
      if (cmd_valid_i && cmd_ready_o) acc_idx = cyc_idx;
      if (wbm_cyc_o) begin
        cyc_len++;
        chk1("stb_with_cyc", wbm_stb_o, 1'b1);
        chk1("cyc_while_rsp", rsp_valid_o, 1'b0);
        if (exp_q.size() == 0) begin
          chk1("bus_unexpected", wbm_cyc_o, 1'b0);
        end else begin
          chk1("bus_we", wbm_we_o, exp_q[0].we);
          chk("bus_adr", wbm_adr_o, exp_q[0].adr);
          chk("bus_dat", wbm_dat_o, exp_q[0].dat);
          chk("bus_sel", {28'h0, wbm_sel_o}, {28'h0, exp_q[0].sel});
        end
      end
      if (rsp_valid_o) begin
        chk1("ready_in_resp", cmd_ready_o, 1'b0);
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            chk1("rsp_unexpected", rsp_valid_o, 1'b0);
          end else begin
            e = exp_q.pop_front();
            cur_dat = rsp_dat_o;
            cur_err = rsp_err_o;
            chk("rsp_dat", rsp_dat_o, e.rdat);
            chk1("rsp_err", rsp_err_o, e.err);
            chk("cyc_len", cyc_len, e.len);
            chk("latency", cyc_idx - acc_idx, e.len + 1);
          end
          cyc_len = 0;
        end else begin
          chk("hold_dat", rsp_dat_o, cur_dat);
          chk1("hold_err", rsp_err_o, cur_err);
        end
        in_rsp = !rsp_ready_i;
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  // Issue one command, queue its expected outcome, and return once it is accepted
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int waits, input bit noack,
                      input logic [31:0] rdata);
    exp_t e;
    bit   tmo;
    bit   got;
    int   k;
    tmo    = (T != 0) && (noack || waits >= T);
    e.we   = we;
    e.adr  = adr;
    e.dat  = dat;
    e.sel  = sel;
    e.err  = tmo;
    e.rdat = tmo ? ERRD : (we ? 32'h0 : rdata);
    e.len  = tmo ? T : waits + 1;
    exp_q.push_back(e);
    r_waits = waits;
    r_noack = noack;
    r_rdata = rdata;
    cmd_valid_i = 1'b1;
    cmd_we_i  = we;
    cmd_adr_i = adr;
    cmd_dat_i = dat;
    cmd_sel_i = sel;
    got = 1'b0;
    k = 0;
    while (!got && k < 100) begin
      @(negedge wb_clk_i);
      got = cmd_ready_o;
      k++;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_wait: cmd_ready 0 expected 1 within 100 cycles");
    end
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    cmd_adr_i = $urandom;
    cmd_dat_i = $urandom;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_q.size() != 0 || rsp_valid_o) && k < 300) begin
      @(negedge wb_clk_i);
      k++;
    end
    if (k >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_wait: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    // asynchronous reset and reset-state checks
    #1 wb_rst_ni = 1'b0;
    #1;
    chk1("rst_cyc", wbm_cyc_o, 1'b0);
    chk1("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_cmd_ready", cmd_ready_o, 1'b0);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    chk1("ready_before_edge", cmd_ready_o, 1'b0);
    @(posedge wb_clk_i); #1;
    chk1("ready_after_edge", cmd_ready_o, 1'b1);

    // zero-wait write
    send(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, 0, 1'b0, 32'h0);
    wait_done();
    // read with 3 wait states and a short consumer stall
    hold = 2;
    send(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 1'b0, 32'hCAFE_0001);
    wait_done();
    // no ack: timeout
    send(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 1'b1, 32'h0);
    wait_done();
    // ack on the last permitted cycle
    send(1'b0, 32'h3000_000C, 32'h0, 4'hC, T - 1, 1'b0, 32'h1357_9BDF);
    wait_done();

    // stray acks while idle must not produce anything
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge wb_clk_i);
      chk1("stray_valid", rsp_valid_o, 1'b0);
      chk1("stray_busy", busy_o, 1'b0);
    end
    @(posedge wb_clk_i); #1;
    stray_ack = 1'b0;

    // backpressure with a second command pending
    hold = 5;
    send(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D);
    begin
      int k = 0;
      while (!rsp_valid_o && k < 50) begin
        @(negedge wb_clk_i);
        k++;
      end
    end
    send(1'b1, 32'h3000_0014, 32'h7777_8888, 4'h1, 0, 1'b0, 32'h0);
    wait_done();

    // reset two cycles into a bus cycle
    send(1'b0, 32'h3000_0018, 32'h0, 4'hF, 0, 1'b1, 32'h0);
    @(posedge wb_clk_i); #2;
    wb_rst_ni = 1'b0;
    #1;
    chk1("midrst_cyc", wbm_cyc_o, 1'b0);
    chk1("midrst_stb", wbm_stb_o, 1'b0);
    chk1("midrst_valid", rsp_valid_o, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    @(posedge wb_clk_i); #1;
    chk1("post_rst_ready", cmd_ready_o, 1'b1);
    chk1("post_rst_busy", busy_o, 1'b0);
    send(1'b0, 32'h3000_001C, 32'h0, 4'hF, 2, 1'b0, 32'h2468_ACE0);
    wait_done();

    // random transfers
    for (int i = 0; i < 25; i++) begin
      hold = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 10), ($urandom_range(0, 7) == 0), $urandom);
      wait_done();
    end

    repeat (3) @(negedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
